// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache line RAM.
// Holds the valid encoding and the flush sweep states.
package cache_pkg;

    localparam int DEF_INDEX = 6;
    localparam int DEF_TAG   = 20;
    localparam int DEF_BYTES = 4;

    localparam logic PRESENT = 1'b1;
    localparam logic ABSENT  = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/cache_flush_seq.sv
// Flush sequencer: walks every entry once, one per cycle.
// Reset lands in SWEEP so valid bits are cleared before first use.
module cache_flush_seq
    import cache_pkg::*;
#(
    parameter int INDEX = DEF_INDEX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic [INDEX-1:0] cnt
);

    localparam logic [INDEX-1:0] LAST = '1;

    sweep_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SWEEP;
            busy  <= 1'b1;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SWEEP: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/cache_line_ram.sv
// Direct-mapped tag/valid/data store with read-first registered reads
// and a background flush sweep that blocks requests while running.
module cache_line_ram
    import cache_pkg::*;
#(
    parameter int INDEX = DEF_INDEX,
    parameter int TAG   = DEF_TAG,
    parameter int BYTES = DEF_BYTES
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [INDEX-1:0]   Index,
    input  logic [TAG-1:0]     TagIn,
    input  logic [8*BYTES-1:0] WrData,
    input  logic [BYTES-1:0]   ByteEn,
    input  logic               Fill,
    input  logic               Store,
    input  logic               InvOne,
    input  logic               FlushAll,
    output logic               Busy,
    output logic [TAG-1:0]     TagOut,
    output logic               ValidOut,
    output logic [8*BYTES-1:0] DataOut,
    output logic               Hit
);

    localparam int DEPTH = 1 << INDEX;

    logic [TAG-1:0]     tag_mem  [DEPTH];
    logic [8*BYTES-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [INDEX-1:0]   cnt;

    logic flush_go;
    logic inv_go;
    logic fill_go;
    logic store_go;

    // One-hot request decode, highest priority wins, all dropped while busy.
    assign flush_go = !Busy && FlushAll;
    assign inv_go   = !Busy && !FlushAll && InvOne;
    assign fill_go  = !Busy && !FlushAll && !InvOne && Fill;
    assign store_go = !Busy && !FlushAll && !InvOne && !Fill && Store;

    cache_flush_seq #(
        .INDEX (INDEX)
    ) u_flush (
        .clk   (Clk),
        .rst_n (Reset_n),
        .start (flush_go),
        .busy  (Busy),
        .cnt   (cnt)
    );

    always_ff @(posedge Clk) begin
        if (Busy) begin
            valid[cnt] <= ABSENT;
        end else if (inv_go) begin
            valid[Index] <= ABSENT;
        end else if (fill_go) begin
            valid[Index]   <= PRESENT;
            tag_mem[Index] <= TagIn;
        end
        if (fill_go || store_go) begin
            for (int b = 0; b < BYTES; b++) begin
                if (ByteEn[b]) begin
                    data_mem[Index][8*b +: 8] <= WrData[8*b +: 8];
                end
            end
        end
    end

    // Accepting a flush already hides valid so it reads 0 for the whole sweep.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            TagOut   <= '0;
            DataOut  <= '0;
            ValidOut <= 1'b0;
            Hit      <= 1'b0;
        end else if (!Busy) begin
            TagOut   <= tag_mem[Index];
            DataOut  <= data_mem[Index];
            ValidOut <= valid[Index] && !FlushAll;
            Hit      <= valid[Index] && !FlushAll
                        && (tag_mem[Index] == TagIn);
        end else begin
            ValidOut <= 1'b0;
            Hit      <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    function automatic logic has_z(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i] === 1'bz) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge Clk) begin
        if (fill_go || store_go) begin
            for (int b = 0; b < BYTES; b++) begin
                if (ByteEn[b] && $isunknown(WrData[8*b +: 8])) begin
                    if (has_z(WrData[8*b +: 8])) begin
                        $error("cache_line_ram: Z in write byte %0d", b);
                        $stop;
                    end else begin
                        $display("cache_line_ram warning: X in write byte %0d", b);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_ram.sv
// Directed bench for cache_line_ram: fill/store/read-first, priority,
// flush sweep timing and mid-sweep reset.
module tb_cache_line_ram;

    localparam int INDEX = 6;
    localparam int TAG   = 20;
    localparam int BYTES = 4;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic [INDEX-1:0]   Index;
    logic [TAG-1:0]     TagIn;
    logic [8*BYTES-1:0] WrData;
    logic [BYTES-1:0]   ByteEn;
    logic               Fill, Store, InvOne, FlushAll;
    logic               Busy;
    logic [TAG-1:0]     TagOut;
    logic               ValidOut;
    logic [8*BYTES-1:0] DataOut;
    logic               Hit;

    int checks = 0;
    int errors = 0;
    int n;

    cache_line_ram #(
        .INDEX (INDEX),
        .TAG   (TAG),
        .BYTES (BYTES)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Index    (Index),
        .TagIn    (TagIn),
        .WrData   (WrData),
        .ByteEn   (ByteEn),
        .Fill     (Fill),
        .Store    (Store),
        .InvOne   (InvOne),
        .FlushAll (FlushAll),
        .Busy     (Busy),
        .TagOut   (TagOut),
        .ValidOut (ValidOut),
        .DataOut  (DataOut),
        .Hit      (Hit)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge Clk);
    endtask

    task automatic idle_req;
        Fill = 0; Store = 0; InvOne = 0; FlushAll = 0;
    endtask

    task automatic do_fill(input logic [INDEX-1:0] idx, input logic [TAG-1:0] t,
                           input logic [31:0] d, input logic [3:0] be);
        Index = idx; TagIn = t; WrData = d; ByteEn = be; Fill = 1;
        tick;
        idle_req;
    endtask

    task automatic rd(input logic [INDEX-1:0] idx, input logic [TAG-1:0] t);
        Index = idx; TagIn = t;
        tick;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (Busy && cnt < 200) begin
            cnt++;
            tick;
        end
    endtask

    initial begin
        idle_req;
        Index = 0; TagIn = 0; WrData = 0; ByteEn = 0;
        #12;
        check("rst_busy", Busy, 1);
        check("rst_valid", ValidOut, 0);
        check("rst_data", DataOut, 0);
        check("rst_tag", TagOut, 0);
        check("rst_hit", Hit, 0);

        @(negedge Clk);
        Reset_n = 1;
        count_busy(n);
        check("rst_sweep_len", n, 64);
        check("idle_after_sweep", Busy, 0);
        rd(3, 0);
        check("empty_valid3", ValidOut, 0);
        rd(63, 0);
        check("empty_valid63", ValidOut, 0);

        do_fill(5, 20'h12345, 32'hDEADBEEF, 4'hF);
        rd(5, 20'h12345);
        check("fill_data", DataOut, 32'hDEADBEEF);
        check("fill_valid", ValidOut, 1);
        check("fill_hit", Hit, 1);
        check("fill_tag", TagOut, 20'h12345);
        rd(5, 20'h12346);
        check("miss_hit", Hit, 0);
        check("miss_valid", ValidOut, 1);

        Index = 5; TagIn = 20'h12345; WrData = 32'hAA; ByteEn = 4'b0001; Store = 1;
        tick;
        check("store_readfirst", DataOut, 32'hDEADBEEF);
        idle_req;
        rd(5, 20'h12345);
        check("store_data", DataOut, 32'hDEADBEAA);
        check("store_tag", TagOut, 20'h12345);
        check("store_valid", ValidOut, 1);
        check("store_hit", Hit, 1);

        do_fill(7, 20'h7, 32'h22222222, 4'hF);
        Index = 7; TagIn = 20'h7; WrData = 32'h11111111; ByteEn = 4'hF; Fill = 1;
        tick;
        check("rf_old", DataOut, 32'h22222222);
        idle_req;
        rd(7, 20'h7);
        check("rf_new", DataOut, 32'h11111111);

        do_fill(9, 20'hABCDE, 32'hFFFFFFFF, 4'h0);
        rd(9, 20'hABCDE);
        check("be0_valid", ValidOut, 1);
        check("be0_hit", Hit, 1);
        check("be0_tag", TagOut, 20'hABCDE);

        Index = 12; WrData = 32'h5A5A5A5A; ByteEn = 4'hF; Store = 1;
        tick;
        idle_req;
        rd(12, 0);
        check("st_inv_valid", ValidOut, 0);
        check("st_inv_data", DataOut, 32'h5A5A5A5A);

        Index = 20; TagIn = 20'h14; WrData = 32'h01020304; ByteEn = 4'hF;
        Fill = 1; Store = 1;
        tick;
        idle_req;
        rd(20, 20'h14);
        check("fill_over_store", ValidOut, 1);
        check("fos_data", DataOut, 32'h01020304);

        Index = 5; TagIn = 20'h12345; WrData = 32'h0; ByteEn = 4'hF;
        InvOne = 1; Fill = 1;
        tick;
        idle_req;
        rd(5, 20'h12345);
        check("inv_over_fill", ValidOut, 0);
        check("iof_data", DataOut, 32'hDEADBEAA);

        Index = 30; WrData = 32'h0; ByteEn = 4'hF; Store = 1;
        tick;
        idle_req;

        Index = 30; TagIn = 20'h30; WrData = 32'h30303030; ByteEn = 4'hF;
        Fill = 1; InvOne = 1; FlushAll = 1;
        tick;
        idle_req;
        check("flush_start", Busy, 1);
        check("flush_valid0", ValidOut, 0);
        Index = 7; TagIn = 20'h7;
        n = 0;
        while (Busy && n < 200) begin
            n++;
            if (n == 11) begin
                Index = 3; TagIn = 20'h3; WrData = 32'h33333333; Fill = 1;
            end
            if (n == 12) begin
                idle_req; Index = 7; TagIn = 20'h7;
            end
            if (n == 20) begin
                check("sweep_valid", ValidOut, 0);
                check("sweep_hit", Hit, 0);
            end
            if (n == 64) FlushAll = 1;
            tick;
        end
        FlushAll = 0;
        check("flush_len", n, 64);
        tick;
        check("late_flush_ignored", Busy, 0);
        rd(3, 20'h3);
        check("dropped_fill", ValidOut, 0);
        rd(7, 20'h7);
        check("flushed7", ValidOut, 0);
        check("flushed7_hit", Hit, 0);
        rd(30, 20'h30);
        check("flush_fill_drop", DataOut, 32'h0);
        check("flush_valid30", ValidOut, 0);

        rd(7, 20'h7);
        FlushAll = 1;
        tick;
        idle_req;
        for (int i = 0; i < 29; i++) tick;
        check("pre_rst_data", DataOut, 32'h11111111);
        Reset_n = 0;
        #1;
        check("mid_rst_data", DataOut, 0);
        check("mid_rst_tag", TagOut, 0);
        check("mid_rst_busy", Busy, 1);
        @(negedge Clk);
        Reset_n = 1;
        count_busy(n);
        check("mid_rst_sweep", n, 64);
        rd(20, 20'h14);
        check("data_kept", DataOut, 32'h01020304);
        check("valid_cleared", ValidOut, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_line_ram.md
CACHE_LINE_RAM -- requirements
Module: cache_line_ram

Interface
REQ-001 The block SHALL have parameter INDEX, default 6, set-index width; DEPTH = 2**INDEX entries.
REQ-002 The block SHALL have parameter TAG, default 20, tag width in bits.
REQ-003 The block SHALL have parameter BYTES, default 4, bytes per entry; data width = 8*BYTES.
REQ-004 The block SHALL have the port Clk  in  1  single clock; all state changes on posedge.
REQ-005 The block SHALL have the port Reset_n  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have the port Index  in  INDEX  entry address for read and write.
REQ-007 The block SHALL have the port TagIn  in  TAG  tag to store on Fill and to compare for Hit.
REQ-008 The block SHALL have the port WrData  in  8*BYTES  write data.
REQ-009 The block SHALL have the port ByteEn  in  BYTES  per-byte write enable.
REQ-010 The block SHALL have the port Fill  in  1  write tag, set valid, write enabled bytes.
REQ-011 The block SHALL have the port Store  in  1  write enabled bytes only; tag and valid unchanged.
REQ-012 The block SHALL have the port InvOne  in  1  clear the valid bit at Index.
REQ-013 The block SHALL have the port FlushAll  in  1  start a sweep clearing every valid bit.
REQ-014 The block SHALL have the port Busy  out  1  sweep in progress; requests ignored.
REQ-015 The block SHALL have the ports TagOut (out, TAG), ValidOut (out, 1) and DataOut (out, 8*BYTES) as registered read results for Index.
REQ-016 The block SHALL have the port Hit  out  1  registered: entry valid and stored tag == TagIn.

Function
REQ-017 Reads SHALL occur every non-Busy cycle, with 1-cycle latency: outputs at edge N reflect Index/TagIn sampled at edge N.
REQ-018 A read and write to the same Index in one cycle SHALL be read-first: outputs show pre-write contents.
REQ-019 Request priority SHALL be FlushAll > InvOne > Fill > Store; only the highest asserted request takes effect in a cycle.
REQ-020 Fill SHALL write TagIn, set valid to PRESENT, and write only the bytes whose ByteEn bit is 1.
REQ-021 Store SHALL write only enabled bytes; a Store to an invalid entry still writes data, and valid stays ABSENT.
REQ-022 ByteEn = 0 with Fill SHALL still update tag and valid.
REQ-023 Flush sequencer states SHALL be IDLE and SWEEP; IDLE->SWEEP on FlushAll (when not Busy); SWEEP clears valid[cnt] with cnt counting 0..DEPTH-1, one entry per cycle; SWEEP->IDLE after clearing entry DEPTH-1.
REQ-024 Busy SHALL be 1 for exactly DEPTH cycles per sweep, starting the cycle after FlushAll is sampled.
REQ-025 While Busy, Fill/Store/InvOne/FlushAll SHALL be ignored (dropped, not queued), and ValidOut and Hit SHALL read 0.
REQ-026 A FlushAll coinciding with the last sweep cycle SHALL be ignored.
REQ-027 The sweep counter SHALL be INDEX bits wide, with no wrap past DEPTH-1 (termination on terminal count).
REQ-028 In simulation only, a Fill/Store with X or Z in an enabled byte SHALL produce a $display warning (X) or an error plus $stop (Z).

Reset
REQ-029 Asserting Reset_n low SHALL asynchronously set TagOut, ValidOut, DataOut and Hit to 0, the counter to 0, and the state to SWEEP with Busy=1.
REQ-030 After Reset_n deasserts, the sweep SHALL run to completion (DEPTH cycles) before any request is accepted; tag and data arrays are not cleared.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from entry 0.

Structure
REQ-032 The shared package cache_pkg SHALL hold PRESENT/ABSENT, the default INDEX/TAG/BYTES values and the sweep state encoding.
REQ-033 The sweep FSM plus counter SHALL be the sub-module cache_flush_seq; the arrays and read path remain in cache_line_ram.

Verification
REQ-034 The bench SHALL cover the following scenario: reset, then idle -> Busy=1 for 64 cycles, then 0; a read of any index gives ValidOut=0.
REQ-035 The bench SHALL cover the following scenario: Fill Index=5, TagIn=0x12345, WrData=0xDEADBEEF, ByteEn=1111; then read Index=5 with TagIn=0x12345 -> next cycle DataOut=0xDEADBEEF, ValidOut=1, Hit=1; with TagIn=0x12346 -> Hit=0.
REQ-036 The bench SHALL cover the following scenario: Store Index=5, WrData=0x000000AA, ByteEn=0001 -> DataOut=0xDEADBEAA, with tag and valid unchanged.
REQ-037 The bench SHALL cover the following scenario: same cycle Fill Index=7 data 0x11111111 and read Index=7 -> the read shows old contents; the following read shows 0x11111111.
REQ-038 The bench SHALL cover the following scenario: FlushAll with Fill/InvOne asserted together -> only the flush starts; a Fill at sweep cycle 10 is dropped; after 64 cycles all ValidOut=0.
REQ-039 The bench SHALL cover the following scenario: Reset_n pulsed low at sweep cycle 30 -> outputs go to 0 immediately, and Busy stays high 64 more cycles after release.
